pudding_loader: RTL and testbench
=================================

Name: pudding_loader

Overview:
- Host-side driver for the PUDDING DAC configuration interface, i.e. the datum/shift/transfer/dir/enable pins.
- Accepts 128-bit words over a valid/ready command port and serialises each one MSB-first into the remote daisy chain, then commits it with a transfer (dir=1).
- Can also read back the remote state register: transfer with dir=0, then shift out while capturing the chain's MSB output.
- Sits in the harness/FPGA wrapper in the same clock domain as the DAC macro.

Parameters:
- WIDTH, 128, daisy-chain and state length in bits.
- SHIFT_DIV, 1, clocks per shift slot (≥1); datum held stable for the whole slot.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  loader can accept a command (high only in IDLE)
- cmd_op  in  2  00 WRITE, 01 READ, 10 SET_EN, 11 NOP
- cmd_data  in  WIDTH  word for WRITE
- cmd_en  in  2  {daisyen, stateen} for SET_EN
- rsp_valid  out  1  readback word available
- rsp_ready  in  1  consumer accepts readback
- rsp_data  out  WIDTH  captured state word
- datum_o  out  1  serial data to chain
- shift_o  out  1  shift strobe
- transfer_o  out  1  transfer strobe
- dir_o  out  1  transfer direction (1: chain→state, 0: state→chain)
- stateen_o  out  1  state DAC enable
- daisyen_o  out  1  chain DAC enable
- sout_i  in  1  chain MSB (uo_out[7]) from the DAC block
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: all outputs 0, FSM in IDLE, shadow and rsp_data cleared, enables 0. Reset asserted mid-operation aborts immediately; any partial chain contents are abandoned.
- Registered outputs: all outputs are registered. shift_o and transfer_o are never high together. dir_o is 0 except while transfer_o is high for a WRITE.
- States: IDLE, SHIFT, XFER, RD_XFER, RD_SHIFT, RSP.
- IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready) dispatches on cmd_op:
  - WRITE: latch cmd_data into shadow, cnt=0, go to SHIFT.
  - READ: go to RD_XFER.
  - SET_EN: update stateen_o/daisyen_o on the next cycle; stay in IDLE.
  - NOP: ignored.
- SHIFT:
  - Slot k (k=0..WIDTH-1) presents datum_o = shadow[WIDTH-1-k] for SHIFT_DIV cycles.
  - shift_o is high only in the last cycle of each slot.
  - After slot WIDTH-1, go to XFER.
- XFER: transfer_o=1, dir_o=1 for one cycle, then IDLE.
- WRITE latency (SHIFT_DIV=1): handshake at edge 0; shift_o high in cycles 1..128; transfer in cycle 129; cmd_ready high again in cycle 130.
- RD_XFER: transfer_o=1, dir_o=0 for one cycle, then RD_SHIFT with cnt=0.
- RD_SHIFT:
  - datum_o=0; same slot timing as SHIFT.
  - On each edge where shift_o is high, capture sout_i into rsp_data bit WIDTH-1-k, so the first capture is state[WIDTH-1].
  - After WIDTH captures, go to RSP.
- RSP: rsp_valid=1 and rsp_data stable until rsp_ready, then IDLE.
- Side effect of READ: the remote chain ends up all-zero; the remote state register is unchanged.
- Counter: cnt is $clog2(WIDTH) bits and the divider counter is $clog2(SHIFT_DIV+1) bits; neither wraps within an operation.
- SET_EN during busy: not possible, because cmd_ready=0.

Optional Feature:
- PUDDING_LOADER_READBACK_EN defined: READ supported as above.
- Not defined:
  - RD_XFER, RD_SHIFT and RSP states plus the capture register are removed.
  - READ is treated as NOP; rsp_valid is tied 0 and rsp_data is tied 0.
  - sout_i is unused.

Decomposition:
- Package pudding_pkg: cmd_op enum (OP_WRITE, OP_READ, OP_SET_EN, OP_NOP), FSM state enum, WIDTH default constant.
- One sub-module: pudding_slot_timer (SHIFT_DIV divider producing the slot-end strobe), shared by SHIFT and RD_SHIFT.

Test Plan:
- Reset, then WRITE 128'h8000_0000_0000_0000_0000_0000_0000_0001 with a behavioural DAC-interface model attached → datum_o=1 on the first shift and the last shift; exactly 128 shift pulses, then one transfer with dir_o=1; model state equals the word; cmd_ready returns in cycle 130.
- WRITE 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, then READ → rsp_data identical; model chain all zeros afterwards; rsp_valid held across 5 cycles of rsp_ready=0.
- SHIFT_DIV=3 WRITE of 128'h5555…5555 → shift_o period 3; datum_o changes only in the cycle after a shift pulse; 384 shift-phase cycles.
- SET_EN cmd_en=2'b10 → daisyen_o=1, stateen_o=0 next cycle; no shift or transfer pulses.
- Assert rst_n low at shift 64 of a WRITE → all outputs 0 immediately, busy=0; a subsequent full WRITE of 128'h1 completes correctly.
- Build without PUDDING_LOADER_READBACK_EN; issue READ → no transfer pulse, rsp_valid stays 0, cmd_ready stays 1.

Source files
------------

// File: rtl/pudding_pkg.sv
// Shared types for the PUDDING DAC configuration loader.
// Command opcodes, FSM states and the default chain length.
package pudding_pkg;

    localparam int PUDDING_WIDTH = 128;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_READ   = 2'b01,
        OP_SET_EN = 2'b10,
        OP_NOP    = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_XFER,
        ST_RD_XFER,
        ST_RD_SHIFT,
        ST_RSP
    } state_e;

endpackage

// File: rtl/pudding_slot_timer.sv
// Shift-slot divider: counts SHIFT_DIV clocks per slot and flags the
// slot's last cycle, both for the current and for the coming cycle.
module pudding_slot_timer #(
    parameter int SHIFT_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic last,
    output logic last_next
);

    localparam int DW = $clog2(SHIFT_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SHIFT_DIV - 1);

    logic [DW-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (clear) begin
            div_d = '0;
        end else if (run) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign last      = (div_q == DIV_LAST);
    assign last_next = (div_d == DIV_LAST);

endmodule

// File: rtl/pudding_loader.sv
// Host-side serial loader/readback for the PUDDING DAC daisy chain.
// Readback support is compiled in with PUDDING_LOADER_READBACK_EN.
module pudding_loader
    import pudding_pkg::*;
#(
    parameter int WIDTH     = PUDDING_WIDTH,
    parameter int SHIFT_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [1:0]       cmd_en,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             datum_o,
    output logic             shift_o,
    output logic             transfer_o,
    output logic             dir_o,
    output logic             stateen_o,
    output logic             daisyen_o,
    input  logic             sout_i,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic datum_q, datum_d, shift_q, shift_d;
    logic xfer_q, xfer_d, dir_q, dir_d;
    logic ready_q, ready_d, busy_q, busy_d;
    logic sten_q, sten_d, dyen_q, dyen_d;
    logic tmr_clear, tmr_run, slot_last, slot_last_next;
    logic accept;
    cmd_op_e op;

`ifdef PUDDING_LOADER_READBACK_EN
    logic [WIDTH-1:0] cap_q, cap_d;
    logic rspv_q, rspv_d;
`endif

    assign op     = cmd_op_e'(cmd_op);
    assign accept = cmd_valid & ready_q;

    pudding_slot_timer #(
        .SHIFT_DIV(SHIFT_DIV)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (tmr_clear),
        .run      (tmr_run),
        .last     (slot_last),
        .last_next(slot_last_next)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        sten_d    = sten_q;
        dyen_d    = dyen_q;
        tmr_clear = 1'b0;
        tmr_run   = 1'b0;
`ifdef PUDDING_LOADER_READBACK_EN
        cap_d     = cap_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_WRITE: begin
                            shadow_d  = cmd_data;
                            cnt_d     = '0;
                            tmr_clear = 1'b1;
                            state_d   = ST_SHIFT;
                        end
`ifdef PUDDING_LOADER_READBACK_EN
                        OP_READ: state_d = ST_RD_XFER;
`endif
                        OP_SET_EN: begin
                            dyen_d = cmd_en[1];
                            sten_d = cmd_en[0];
                        end
                        default: ;
                    endcase
                end
            end
            ST_SHIFT: begin
                tmr_run = 1'b1;
                // the shadow shifts so its MSB is always the current datum
                if (slot_last) begin
                    shadow_d = shadow_q << 1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_XFER;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_XFER: state_d = ST_IDLE;
`ifdef PUDDING_LOADER_READBACK_EN
            ST_RD_XFER: begin
                cnt_d     = '0;
                tmr_clear = 1'b1;
                state_d   = ST_RD_SHIFT;
            end
            ST_RD_SHIFT: begin
                tmr_run = 1'b1;
                if (slot_last) begin
                    cap_d = {cap_q[WIDTH-2:0], sout_i};
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_RSP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // outputs describe the cycle that state_d/cnt_d/shadow_d will hold
        datum_d = (state_d == ST_SHIFT) && shadow_d[WIDTH-1];
        shift_d = ((state_d == ST_SHIFT) || (state_d == ST_RD_SHIFT))
                  && slot_last_next;
        xfer_d  = (state_d == ST_XFER) || (state_d == ST_RD_XFER);
        dir_d   = (state_d == ST_XFER);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
`ifdef PUDDING_LOADER_READBACK_EN
        rspv_d  = (state_d == ST_RSP);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            datum_q  <= 1'b0;
            shift_q  <= 1'b0;
            xfer_q   <= 1'b0;
            dir_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            sten_q   <= 1'b0;
            dyen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            datum_q  <= datum_d;
            shift_q  <= shift_d;
            xfer_q   <= xfer_d;
            dir_q    <= dir_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            sten_q   <= sten_d;
            dyen_q   <= dyen_d;
        end
    end

`ifdef PUDDING_LOADER_READBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q  <= '0;
            rspv_q <= 1'b0;
        end else begin
            cap_q  <= cap_d;
            rspv_q <= rspv_d;
        end
    end

    assign rsp_valid = rspv_q;
    assign rsp_data  = cap_q;
`else
    logic unused_rd;
    assign unused_rd = sout_i ^ rsp_ready;
    assign rsp_valid = 1'b0;
    assign rsp_data  = '0;
`endif

    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign datum_o    = datum_q;
    assign shift_o    = shift_q;
    assign transfer_o = xfer_q;
    assign dir_o      = dir_q;
    assign stateen_o  = sten_q;
    assign daisyen_o  = dyen_q;

endmodule

// File: tb/tb_pudding_loader.sv
// Bench for pudding_loader: two instances (SHIFT_DIV 1 and 3), a remote
// DAC chain/state model and a waveform model checked every cycle.
module tb_pudding_loader;

`ifdef PUDDING_LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int M_IDLE = 0, M_WR = 1, M_RD = 2, M_RSP = 3;
    localparam logic [127:0] W1 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] W2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    localparam logic [127:0] W3 = {32{4'h5}};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         cv [2], crdy [2], rspv [2], rr [2];
    logic [1:0]   cop [2], cen [2];
    logic [127:0] cd [2], rdat [2];
    logic datum [2], shift [2], xfer [2], dir [2];
    logic sten [2], dyen [2], sout [2], busy [2];

    logic [127:0] chain [2], chain_nx [2], rst_st [2], rst_nx [2];
    logic [127:0] word [2], exp_rsp [2];
    logic [1:0]   en_m [2];
    int  mode [2], t [2], nshift [2], nxfer [2];
    int  dv [2] = '{1, 3};
    bit  rdy_ok [2];
    bit  done [2];
    int  cyc = 0;
    int  errors = 0, checks = 0;
    logic [8:0] ev, av;

    assign sout[0] = chain[0][127];
    assign sout[1] = chain[1][127];

    pudding_loader #(.WIDTH(128), .SHIFT_DIV(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cv[0]), .cmd_ready(crdy[0]),
        .cmd_op(cop[0]), .cmd_data(cd[0]), .cmd_en(cen[0]),
        .rsp_valid(rspv[0]), .rsp_ready(rr[0]), .rsp_data(rdat[0]),
        .datum_o(datum[0]), .shift_o(shift[0]), .transfer_o(xfer[0]),
        .dir_o(dir[0]), .stateen_o(sten[0]), .daisyen_o(dyen[0]),
        .sout_i(sout[0]), .busy(busy[0]));

    pudding_loader #(.WIDTH(128), .SHIFT_DIV(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cv[1]), .cmd_ready(crdy[1]),
        .cmd_op(cop[1]), .cmd_data(cd[1]), .cmd_en(cen[1]),
        .rsp_valid(rspv[1]), .rsp_ready(rr[1]), .rsp_data(rdat[1]),
        .datum_o(datum[1]), .shift_o(shift[1]), .transfer_o(xfer[1]),
        .dir_o(dir[1]), .stateen_o(sten[1]), .daisyen_o(dyen[1]),
        .sout_i(sout[1]), .busy(busy[1]));

    always @(posedge clk) cyc <= cyc + 1;

    // remote DAC block: chain and state registers react at the clock edge
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            chain[i]  = chain_nx[i];
            rst_st[i] = rst_nx[i];
        end
    end

    // per-cycle compare of both DUTs against the command-level model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ev = '0;
            if (rst_n) begin
                ev[1:0] = en_m[i];
                case (mode[i])
                    M_IDLE: ev[3] = rdy_ok[i];
                    M_WR: begin
                        ev[4] = 1'b1;
                        if (t[i] < 128 * dv[i]) begin
                            ev[8] = word[i][127 - t[i] / dv[i]];
                            ev[7] = (t[i] % dv[i]) == dv[i] - 1;
                        end else begin
                            ev[6] = 1'b1;
                            ev[5] = 1'b1;
                        end
                    end
                    M_RD: begin
                        ev[4] = 1'b1;
                        if (t[i] == 0) ev[6] = 1'b1;
                        else ev[7] = ((t[i] - 1) % dv[i]) == dv[i] - 1;
                    end
                    default: begin
                        ev[4] = 1'b1;
                        ev[2] = 1'b1;
                    end
                endcase
            end
            av = {datum[i], shift[i], xfer[i], dir[i], busy[i],
                  crdy[i], rspv[i], dyen[i], sten[i]};
            checks++;
            if (av !== ev) begin
                errors++;
                $display("FAIL cycle dut%0d cyc=%0d t=%0d outs got=%b want=%b",
                         i, cyc, t[i], av, ev);
            end
            if (!RB || ev[2]) begin
                checks++;
                if (rdat[i] !== (RB ? exp_rsp[i] : 128'h0)) begin
                    errors++;
                    $display("FAIL rsp_data dut%0d cyc=%0d got=%h want=%h",
                             i, cyc, rdat[i], RB ? exp_rsp[i] : 128'h0);
                end
            end
            if (shift[i] === 1'b1) nshift[i]++;
            if (xfer[i] === 1'b1) nxfer[i]++;

            chain_nx[i] = chain[i];
            rst_nx[i]   = rst_st[i];
            if (shift[i] === 1'b1) chain_nx[i] = {chain[i][126:0], datum[i]};
            if (xfer[i] === 1'b1) begin
                if (dir[i]) rst_nx[i] = chain[i];
                else chain_nx[i] = rst_st[i];
            end

            if (!rst_n) begin
                mode[i]   = M_IDLE;
                rdy_ok[i] = 1'b0;
                en_m[i]   = 2'b00;
            end else begin
                case (mode[i])
                    M_IDLE: if (rdy_ok[i] && cv[i]) begin
                        case (cop[i])
                            2'b00: begin
                                mode[i] = M_WR;
                                t[i]    = 0;
                                word[i] = cd[i];
                            end
                            2'b01: if (RB) begin
                                mode[i]    = M_RD;
                                t[i]       = 0;
                                exp_rsp[i] = rst_st[i];
                            end
                            2'b10: en_m[i] = cen[i];
                            default: ;
                        endcase
                    end
                    M_WR: if (t[i] == 128 * dv[i]) mode[i] = M_IDLE; else t[i]++;
                    M_RD: if (t[i] == 128 * dv[i]) mode[i] = M_RSP; else t[i]++;
                    default: if (rr[i]) mode[i] = M_IDLE;
                endcase
                rdy_ok[i] = 1'b1;
            end
        end
    end

    task automatic check(input string nm, input logic [127:0] got,
                         input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic issue(input int i, input logic [1:0] op,
                         input logic [127:0] d, input logic [1:0] en,
                         output int acc);
        @(posedge clk);
        #1;
        cv[i] = 1'b1; cop[i] = op; cd[i] = d; cen[i] = en;
        acc = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (crdy[i]) begin
                acc = cyc;
                @(posedge clk);
                #1;
                break;
            end
        end
        cv[i] = 1'b0;
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL issue dut%0d timeout", i);
        end
    endtask

    task automatic wait_ready(input int i, output int at);
        at = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (crdy[i]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++; errors++;
            $display("FAIL wait_ready dut%0d timeout", i);
        end
    endtask

    task automatic rnd_run(input int i, input int n);
        int r, acc, at;
        logic [1:0] op, en;
        logic [127:0] d;
        for (int k = 0; k < n; k++) begin
            r  = $urandom_range(0, 9);
            op = r < 5 ? 2'b00 : r < 7 ? 2'b01 : r < 9 ? 2'b10 : 2'b11;
            d  = {$urandom, $urandom, $urandom, $urandom};
            en = 2'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(i, op, d, en, acc);
            wait_ready(i, at);
            if (op == 2'b00) check($sformatf("rnd_state%0d", i), rst_st[i], d);
            if (op == 2'b01 && RB) check($sformatf("rnd_chain%0d", i), chain[i], 128'h0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, at, got;
        for (int i = 0; i < 2; i++) begin
            cv[i] = 0; cop[i] = 0; cd[i] = 0; cen[i] = 0; rr[i] = 1;
            chain[i] = 0; chain_nx[i] = 0; rst_st[i] = 0; rst_nx[i] = 0;
            word[i] = 0; exp_rsp[i] = 0; en_m[i] = 0; mode[i] = M_IDLE;
            t[i] = 0; nshift[i] = 0; nxfer[i] = 0; rdy_ok[i] = 0; done[i] = 0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_outs%0d", i),
                  {datum[i], shift[i], xfer[i], dir[i], busy[i], crdy[i],
                   rspv[i], dyen[i], sten[i]}, 0);
            check($sformatf("reset_rsp%0d", i), rdat[i], 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        nshift[0] = 0; nxfer[0] = 0;
        issue(0, 2'b00, W1, 2'b00, acc);
        wait_ready(0, at);
        check("t1_latency", 128'(at - acc), 130);
        check("t1_shifts", 128'(nshift[0]), 128);
        check("t1_xfers", 128'(nxfer[0]), 1);
        check("t1_state", rst_st[0], W1);

        issue(0, 2'b00, W2, 2'b00, acc);
        wait_ready(0, at);
        rr[0] = 1'b0; nxfer[0] = 0;
        issue(0, 2'b01, 128'h0, 2'b00, acc);
        if (RB) begin
            got = 0;
            for (int k = 0; k < 1000 && got == 0; k++) begin
                @(negedge clk);
                if (rspv[0]) got = 1;
            end
            check("t2_rsp_seen", 128'(got), 1);
            check("t2_rsp_data", rdat[0], W2);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check("t2_rsp_hold", {rspv[0], rdat[0]}, {1'b1, W2});
            end
            @(posedge clk);
            #1 rr[0] = 1'b1;
            wait_ready(0, at);
            check("t2_chain_zero", chain[0], 128'h0);
            check("t2_state_kept", rst_st[0], W2);
            check("t2_xfers", 128'(nxfer[0]), 1);
        end else begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check("t2_read_nop", {crdy[0], rspv[0]}, 2'b10);
            end
            check("t2_no_xfer", 128'(nxfer[0]), 0);
            rr[0] = 1'b1;
        end

        nshift[1] = 0; nxfer[1] = 0;
        issue(1, 2'b00, W3, 2'b00, acc);
        wait_ready(1, at);
        check("t3_latency", 128'(at - acc), 386);
        check("t3_shifts", 128'(nshift[1]), 128);
        check("t3_state", rst_st[1], W3);

        nshift[0] = 0; nxfer[0] = 0;
        issue(0, 2'b10, 128'h0, 2'b10, acc);
        repeat (3) @(negedge clk);
        check("t4_en", {dyen[0], sten[0]}, 2'b10);
        check("t4_pulses", 128'(nshift[0] + nxfer[0]), 0);

        nshift[0] = 0;
        issue(0, 2'b00, ~W2, 2'b00, acc);
        for (int k = 0; k < 500 && nshift[0] < 64; k++) @(negedge clk);
        check("t5_reached64", 128'(nshift[0]), 64);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_reset_outs", {datum[0], shift[0], xfer[0], dir[0], busy[0],
                                crdy[0], rspv[0], dyen[0], sten[0]}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(0, 2'b00, 128'h1, 2'b00, acc);
        wait_ready(0, at);
        check("t5_rewrite", rst_st[0], 128'h1);

        fork
            begin rnd_run(0, 16); done[0] = 1; end
            begin rnd_run(1, 6); done[1] = 1; end
            begin
                while (!(done[0] && done[1])) begin
                    @(posedge clk);
                    #1;
                    rr[0] = 1'($urandom_range(0, 1));
                    rr[1] = 1'($urandom_range(0, 1));
                end
            end
        join
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
